prga_decrypt_fsm: RTL and testbench

RC4 keystream generation and decryption stage; runs after `shuffle_fsm` signals `shuffle_finished`. It walks the key-scheduled S memory with the RC4 PRGA (i/j swap, keystream byte f), XORs each f with the matching encrypted ROM byte, and writes the plaintext to a decrypted-data RAM. It owns the S memory port only while busy; the top-level S-memory mux selects its address/data/wren in the decrypt state.

---
 rtl/prga_decrypt_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_prga_decrypt_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm: RC4 PRGA keystream generation and decryption stage.
// Walks the key-scheduled S memory, XORs each keystream byte with the matching
// encrypted ROM byte and writes the plaintext to the decrypted-data RAM.
// Optional feature macro: PRGA_CHAR_CHECK_EN (plaintext character check with
// early abort; when undefined, invalid is tied low and every byte is processed).
module prga_decrypt_fsm #(
    parameter int unsigned MSG_LENGTH     = 32,
    parameter int unsigned MSG_ADDR_WIDTH = 5
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                s_data_in,
    output logic [7:0]                s_address_out,
    output logic [7:0]                s_data_out,
    output logic                      s_write_enable_out,
    output logic [MSG_ADDR_WIDTH-1:0] rom_address_out,
    input  logic [7:0]                rom_data_in,
    output logic [MSG_ADDR_WIDTH-1:0] d_address_out,
    output logic [7:0]                d_data_out,
    output logic                      d_write_enable_out,
    output logic                      busy,
    output logic                      done,
    output logic                      invalid
);

    localparam logic [MSG_ADDR_WIDTH-1:0] KLast = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

    typedef enum logic [3:0] {
        StIdle,
        StIncI,
        StWaitSi,
        StReadSi,
        StAddrSj,
        StWaitSj,
        StReadSj,
        StWriteSi,
        StWriteSj,
        StAddrF,
        StWaitF,
        StReadF,
        StWriteD,
        StNext,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [7:0]                i_q, i_d;
    logic [7:0]                j_q, j_d;
    logic [7:0]                si_q, si_d;
    logic [7:0]                sj_q, sj_d;
    logic [7:0]                f_q, f_d;
    logic [7:0]                e_q, e_d;
    logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
    logic                      abort;

`ifdef PRGA_CHAR_CHECK_EN
    logic invalid_q, invalid_d;
    logic [7:0] plain;

    assign plain   = f_q ^ e_q;
    assign abort   = invalid_q;
    assign invalid = invalid_q;

    // Sticky plaintext-check flag: cleared on start, set in WRITE_D on a bad byte.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            invalid_q <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    // Only space and lower-case letters count as valid plaintext.
    always_comb begin
        invalid_d = invalid_q;
        if ((state_q == StIdle || state_q == StDone) && start) begin
            invalid_d = 1'b0;
        end else if (state_q == StWriteD) begin
            if (!(plain == 8'h20 || (plain >= 8'h61 && plain <= 8'h7a))) begin
                invalid_d = 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign invalid = 1'b0;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= StIdle;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            f_q     <= 8'h00;
            e_q     <= 8'h00;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            e_q     <= e_d;
            k_q     <= k_d;
        end
    end

    // Next-state, datapath updates and state-decoded memory interface outputs.
    // Read addresses stay on the bus through the READ state so the
    // registered-output S/ROM memories return q for the held address.
    always_comb begin
        state_d            = state_q;
        i_d                = i_q;
        j_d                = j_q;
        si_d               = si_q;
        sj_d               = sj_q;
        f_d                = f_q;
        e_d                = e_q;
        k_d                = k_q;
        s_address_out      = 8'h00;
        s_data_out         = 8'h00;
        s_write_enable_out = 1'b0;
        rom_address_out    = '0;
        d_address_out      = '0;
        d_data_out         = 8'h00;
        d_write_enable_out = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                busy = 1'b0;
                done = (state_q == StDone);
                if (start) begin
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    k_d     = '0;
                    state_d = StIncI;
                end
            end
            StIncI: begin
                i_d           = i_q + 8'd1;
                s_address_out = i_q + 8'd1;
                state_d       = StWaitSi;
            end
            StWaitSi: begin
                s_address_out = i_q;
                state_d       = StReadSi;
            end
            StReadSi: begin
                s_address_out = i_q;
                si_d          = s_data_in;
                j_d           = j_q + s_data_in;
                state_d       = StAddrSj;
            end
            StAddrSj: begin
                s_address_out = j_q;
                state_d       = StWaitSj;
            end
            StWaitSj: begin
                s_address_out = j_q;
                state_d       = StReadSj;
            end
            StReadSj: begin
                s_address_out = j_q;
                sj_d          = s_data_in;
                state_d       = StWriteSi;
            end
            StWriteSi: begin
                s_address_out      = i_q;
                s_data_out         = sj_q;
                s_write_enable_out = 1'b1;
                state_d            = StWriteSj;
            end
            StWriteSj: begin
                // i == j rewrites the same location with the same value.
                s_address_out      = j_q;
                s_data_out         = si_q;
                s_write_enable_out = 1'b1;
                state_d            = StAddrF;
            end
            StAddrF: begin
                s_address_out   = si_q + sj_q;
                rom_address_out = k_q;
                state_d         = StWaitF;
            end
            StWaitF: begin
                s_address_out   = si_q + sj_q;
                rom_address_out = k_q;
                state_d         = StReadF;
            end
            StReadF: begin
                s_address_out   = si_q + sj_q;
                rom_address_out = k_q;
                f_d             = s_data_in;
                e_d             = rom_data_in;
                state_d         = StWriteD;
            end
            StWriteD: begin
                d_address_out      = k_q;
                d_data_out         = f_q ^ e_q;
                d_write_enable_out = 1'b1;
                state_d            = StNext;
            end
            StNext: begin
                if (k_q == KLast || abort) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StIncI;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// tb_prga_decrypt_fsm: table-driven and randomized checks of prga_decrypt_fsm
// against a plain-arithmetic RC4 PRGA reference model.
module tb_prga_decrypt_fsm;

    localparam int ML = 32;
    localparam int AW = 5;
`ifdef PRGA_CHAR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [7:0]    s_q      = 8'h00;
    logic [7:0]    rom_q    = 8'h00;
    logic [7:0]    s_addr, s_dout;
    logic          s_we;
    logic [AW-1:0] rom_addr, d_addr;
    logic [7:0]    d_dout;
    logic          d_we, busy, done, invalid;

    prga_decrypt_fsm #(
        .MSG_LENGTH     (ML),
        .MSG_ADDR_WIDTH (AW)
    ) dut (
        .CLOCK_50           (CLOCK_50),
        .reset              (reset),
        .start              (start),
        .s_data_in          (s_q),
        .s_address_out      (s_addr),
        .s_data_out         (s_dout),
        .s_write_enable_out (s_we),
        .rom_address_out    (rom_addr),
        .rom_data_in        (rom_q),
        .d_address_out      (d_addr),
        .d_data_out         (d_dout),
        .d_write_enable_out (d_we),
        .busy               (busy),
        .done               (done),
        .invalid            (invalid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Memory models and write bookkeeping
    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] rom [ML];
    logic [7:0] d_seen [ML];
    int         d_edge [ML];
    int         cyc = 0, s_wr_cnt = 0, d_wr_cnt = 0, overlap_cnt = 0;
    bit         load_s = 1'b0;

    // Reference model results
    logic [7:0] exp_d [ML];
    logic [7:0] exp_s [256];
    int         exp_n;
    bit         exp_inv;

    int n_checks = 0, n_fail = 0;

    // Synchronous-read S/ROM memories and the decrypted RAM
    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (load_s) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
            for (int n = 0; n < ML; n++) begin
                d_seen[n] <= 8'hxx;
                d_edge[n] <= -1;
            end
        end else if (s_we) begin
            s_mem[s_addr] <= s_dout;
            s_wr_cnt      <= s_wr_cnt + 1;
        end
        s_q   <= s_mem[s_addr];
        rom_q <= rom[rom_addr];
        if (d_we && !load_s) begin
            d_seen[d_addr] <= d_dout;
            d_edge[d_addr] <= cyc + 1;
            d_wr_cnt       <= d_wr_cnt + 1;
        end
    end

    always @(negedge CLOCK_50) begin
        if (s_we && d_we) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // RC4 PRGA straight from its definition
    task automatic ref_model();
        logic [7:0] s [256];
        int i = 0, j = 0;
        logic [7:0] t, p;
        for (int n = 0; n < 256; n++) s[n] = s_init[n];
        exp_n   = 0;
        exp_inv = 1'b0;
        for (int k = 0; k < ML; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            p = s[(int'(s[i]) + int'(s[j])) % 256] ^ rom[k];
            exp_d[k] = p;
            exp_n    = k + 1;
            if (CHK && !(p == 8'h20 || (p >= 8'h61 && p <= 8'h7a))) begin
                exp_inv = 1'b1;
                break;
            end
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
    endtask

    task automatic load_mem();
        @(negedge CLOCK_50);
        load_s = 1'b1;
        @(negedge CLOCK_50);
        load_s = 1'b0;
    endtask

    task automatic set_identity();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endtask

    // Pulse start (edge 0), optionally pulse it again while busy, then check
    // timing, write counts, plaintext bytes and final S contents.
    task automatic run_and_check(input string name, input int busy_start_at);
        int base_s, base_d, start_cyc, n, done_edge, mism;
        ref_model();
        base_s = s_wr_cnt;
        base_d = d_wr_cnt;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        check({name, " busy@edge0"}, 32'(busy), 32'd1);
        check({name, " done@edge0"}, 32'(done), 32'd0);
        n         = 0;
        done_edge = -1;
        while (n < 13 * ML + 50) begin
            if (n + 1 == busy_start_at) start = 1'b1;
            @(posedge CLOCK_50);
            #1;
            n++;
            start = 1'b0;
            if (done) begin
                done_edge = n;
                break;
            end
        end
        check({name, " done edge"}, 32'(done_edge), 32'(13 * exp_n));
        check({name, " busy in done"}, 32'(busy), 32'd0);
        check({name, " invalid"}, 32'(invalid), 32'(exp_inv));
        check({name, " d writes"}, 32'(d_wr_cnt - base_d), 32'(exp_n));
        check({name, " s writes"}, 32'(s_wr_cnt - base_s), 32'(2 * exp_n));
        for (int k = 0; k < exp_n; k++) begin
            check($sformatf("%s d[%0d]", name, k), 32'(d_seen[k]), 32'(exp_d[k]));
            check($sformatf("%s d[%0d] edge", name, k), 32'(d_edge[k] - start_cyc),
                  32'(13 * k + 12));
        end
        mism = 0;
        for (int m = 0; m < 256; m++) if (s_mem[m] !== exp_s[m]) mism++;
        check({name, " S final mismatches"}, 32'(mism), 32'd0);
    endtask

    typedef struct {
        string      name;
        bit         wrap;
        logic [7:0] rom0;
        logic [7:0] rom1;
        logic [7:0] exp_d0;
        logic [7:0] exp_d1;
        bit         chk_d1;
        int         busy_at;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int base_s, base_d;
        logic [7:0] t;
        int r;

        tbl[0] = '{"ident",      1'b0, 8'h00, 8'h00, 8'h02, 8'h05, 1'b1, -1};
        tbl[1] = '{"text",       1'b0, 8'h63, 8'h64, 8'h61, 8'h61, 1'b1, -1};
        tbl[2] = '{"wrap",       1'b1, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, -1};
        tbl[3] = '{"busy_start", 1'b0, 8'h00, 8'h00, 8'h02, 8'h05, 1'b1, 50};

        for (int n = 0; n < ML; n++) rom[n] = 8'h00;
        set_identity();
        load_mem();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("reset s bus", {16'h0, s_addr, s_dout}, 32'h0);
        check("reset ctl", {17'h0, s_we, rom_addr, d_addr, d_dout, d_we, busy, done, invalid},
              32'h0);
        @(negedge CLOCK_50);
        reset = 1'b1;

        // Table-driven scenarios; later entries also exercise restart from DONE
        for (int v = 0; v < 4; v++) begin
            set_identity();
            if (tbl[v].wrap) begin
                s_init[1]     = 8'hff;
                s_init[8'hff] = 8'h03;
            end
            for (int n = 0; n < ML; n++) rom[n] = 8'h00;
            rom[0] = tbl[v].rom0;
            rom[1] = tbl[v].rom1;
            load_mem();
            run_and_check(tbl[v].name, tbl[v].busy_at);
            check({tbl[v].name, " d0 spec"}, 32'(d_seen[0]), 32'(tbl[v].exp_d0));
            if (tbl[v].chk_d1 && exp_n > 1)
                check({tbl[v].name, " d1 spec"}, 32'(d_seen[1]), 32'(tbl[v].exp_d1));
        end

        // Reset mid-operation: aborts, then nothing happens until a new start
        set_identity();
        for (int n = 0; n < ML; n++) rom[n] = 8'h00;
        load_mem();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (99) @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("midreset s bus", {16'h0, s_addr, s_dout}, 32'h0);
        check("midreset ctl",
              {17'h0, s_we, rom_addr, d_addr, d_dout, d_we, busy, done, invalid}, 32'h0);
        @(negedge CLOCK_50);
        reset  = 1'b1;
        base_s = s_wr_cnt;
        base_d = d_wr_cnt;
        repeat (40) @(negedge CLOCK_50);
        check("post-reset writes", 32'((s_wr_cnt - base_s) + (d_wr_cnt - base_d)), 32'd0);
        check("post-reset busy", 32'(busy), 32'd0);
        set_identity();
        load_mem();
        run_and_check("rerun", -1);

        // Random key-scheduled permutations and random ciphertext
        for (int v = 0; v < 3; v++) begin
            set_identity();
            for (int n = 255; n > 0; n--) begin
                r = int'($urandom_range(0, n));
                t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
            end
            for (int n = 0; n < ML; n++) rom[n] = 8'($urandom_range(0, 255));
            load_mem();
            run_and_check($sformatf("rand%0d", v), -1);
        end

        check("wren overlap cycles", 32'(overlap_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
